// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the datapath ALU execute stage
package alu_pkg;

    localparam int OPW   = 8;
    localparam int ITERS = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } alu_state_e;

endpackage

// File: rtl/seq_muldiv_unit.sv
// rtl/seq_muldiv_unit.sv - iterative unsigned shift-add multiplier / restoring divider
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load operands and begin ITERS iterations
//   is_div              1 = restoring divide a/b, 0 = multiply a*b
//   a, b                operands, sampled on start
//   last                high during the final iteration cycle
//   product             accumulator value after this cycle's iteration
//   quotient, remainder low/high halves of the same post-iteration value
//
// The outputs are the combinational result of the current iteration, so the
// owner can register the finished value on the same edge that takes the last
// step, without an extra cycle.
module seq_muldiv_unit #(
    parameter int OPW   = alu_pkg::OPW,
    parameter int ITERS = alu_pkg::ITERS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_div,
    input  logic [OPW-1:0]     a,
    input  logic [OPW-1:0]     b,
    output logic               last,
    output logic [2*OPW-1:0]   product,
    output logic [OPW-1:0]     quotient,
    output logic [OPW-1:0]     remainder
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(ITERS);

    // acc_q holds {partial/remainder, multiplier/dividend-quotient}
    logic [2*OPW-1:0] acc_q;
    logic [OPW-1:0]   opnd_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    logic [OPW-1:0]   hi;
    logic [OPW-1:0]   lo;
    logic [OPW:0]     mul_sum;
    logic [OPW:0]     div_shift;
    logic [OPW:0]     div_diff;
    logic [2*OPW-1:0] mul_next;
    logic [2*OPW-1:0] div_next;
    logic [2*OPW-1:0] step_next;

    always_comb begin
        hi = acc_q[2*OPW-1:OPW];
        lo = acc_q[OPW-1:0];

        // Multiply: add the multiplicand when the current multiplier LSB is
        // set, then shift the whole {carry, partial, multiplier} right by one.
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, lo[OPW-1:1]};

        // Divide: bring the next dividend bit into the partial remainder and
        // trial-subtract; bit OPW of the difference set means it went negative.
        div_shift = {hi, lo[OPW-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[OPW]) begin
            div_next = {div_shift[OPW-1:0], lo[OPW-2:0], 1'b0};
        end else begin
            div_next = {div_diff[OPW-1:0], lo[OPW-2:0], 1'b1};
        end

        step_next = div_q ? div_next : mul_next;
    end

    assign last      = active_q && (cnt_q == '0);
    assign product   = step_next;
    assign quotient  = step_next[OPW-1:0];
    assign remainder = step_next[2*OPW-1:OPW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            acc_q    <= is_div ? {{OPW{1'b0}}, a} : {{OPW{1'b0}}, b};
            opnd_q   <= is_div ? b : a;
            div_q    <= is_div;
            cnt_q    <= CNT_W'(ITERS - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            acc_q <= step_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - multi-cycle execute stage: ADD/SUB single cycle, MUL/DIV iterative
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low; 0 clears all state
//   enable       request, sampled only in IDLE
//   opcode       0=ADD 1=SUB 2=MUL 3=DIV, others illegal
//   a, b         operands, latched at start
//   done         one-cycle completion pulse
//   busy         high from the cycle after start through the done cycle
//   result       held from done until the next done
//   div_by_zero  set with done for DIV by zero
//   illegal_op   set with done for opcodes 4..15
module datapath_alu #(
    parameter int WIDTH = 16,
    parameter int OPW   = alu_pkg::OPW,
    parameter int ITERS = alu_pkg::ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       opcode,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             illegal_op
);
    import alu_pkg::*;

    alu_state_e       state_q;
    alu_state_e       state_d;
    logic [3:0]       op_q;
    logic [OPW-1:0]   a_q;
    logic [OPW-1:0]   b_q;

    logic             start;
    logic             md_start;
    logic             md_is_div;
    logic             md_last;
    logic [2*OPW-1:0] md_product;
    logic [OPW-1:0]   md_quotient;
    logic [OPW-1:0]   md_remainder;
    logic             is_iter;
    logic             finish;

    logic [WIDTH-1:0] res_d;
    logic             dbz_d;
    logic             ill_d;

    assign start     = (state_q == IDLE) && enable;
    assign md_is_div = (opcode == OP_DIV);
    // Division by zero is resolved at start, so the iterative unit never runs for it.
    assign md_start  = start && ((opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0)));
    assign is_iter   = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
    assign finish    = (state_q == EXEC) && (state_d == DONE);

    seq_muldiv_unit #(
        .OPW   (OPW),
        .ITERS (ITERS)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (reset),
        .start     (md_start),
        .is_div    (md_is_div),
        .a         (a),
        .b         (b),
        .last      (md_last),
        .product   (md_product),
        .quotient  (md_quotient),
        .remainder (md_remainder)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!is_iter || md_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        res_d = '0;
        dbz_d = 1'b0;
        ill_d = 1'b0;
        case (op_q)
            OP_ADD: res_d = WIDTH'(a_q) + WIDTH'(b_q);
            OP_SUB: res_d = WIDTH'(a_q) - WIDTH'(b_q);
            OP_MUL: res_d = WIDTH'(md_product);
            OP_DIV: begin
                if (b_q == '0) begin
                    res_d = WIDTH'({a_q, {OPW{1'b1}}});
                    dbz_d = 1'b1;
                end else begin
                    res_d = WIDTH'({md_remainder, md_quotient});
                end
            end
            default: ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q        <= opcode;
                a_q         <= a;
                b_q         <= b;
                div_by_zero <= 1'b0;
                illegal_op  <= 1'b0;
            end
            if (finish) begin
                result      <= res_d;
                div_by_zero <= dbz_d;
                illegal_op  <= ill_d;
            end
        end
    end

    assign done = (state_q == DONE);
    assign busy = (state_q == EXEC) || (state_q == DONE);

endmodule
